par_read_ctrl: RTL
==================

PAR_READ_CTRL -- requirements
Module: par_read_ctrl

Interface
REQ-001 SHALL have parameter SlaveCount, default 5, total slaves including DefaultSlave.
REQ-002 SHALL have parameter SelSlaveCount, default 3, width of Rsel_Slave.
REQ-003 SHALL have port ACLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port ARVALID_M / ARREADY_M  input / output  1 / 1  master AR handshake.
REQ-006 SHALL have port ARADDR_M  input  32  master read address.
REQ-007 SHALL have port ARLEN_M  input  4  burst length minus one.
REQ-008 SHALL have port ARVALID_SS / ARREADY_SS  output / input  SlaveCount-1 / SlaveCount-1  per-real-slave AR handshake.
REQ-009 SHALL have port ARVALID_DS / ARREADY_DS  output / input  1 / 1  DefaultSlave AR handshake.
REQ-010 SHALL have port RVALID, RREADY, RLAST  input  1 each  R beat seen at master side, after the S2M mux.
REQ-011 SHALL have port state  output  2  read-channel state, driven to the R S2M mux.
REQ-012 SHALL have port Rsel_Slave  output  SelSlaveCount  selected slave index, driven to the R S2M mux.
REQ-013 SHALL have port prot_err  output  1  sticky burst-length mismatch flag.

Function
REQ-014 SHALL implement states IDLE, ARTRANS, RTRANS with encodings READSTATE_IDLE/ARTRANS/RTRANS; state output = current state register.
REQ-015 IDLE: ARREADY_M=0, all ARVALID_SS/ARVALID_DS=0; ARVALID_M=1 -> latch decoded index into sel register, latch ARLEN_M into beat counter, go ARTRANS next cycle.
REQ-016 Decode: ARADDR_M[31:16] compared against package region table; slave i when in region i; no match -> DefaultSlave index SlaveCount-1.
REQ-017 ARTRANS: ARVALID to selected target only = ARVALID_M; ARREADY_M = selected target's ARREADY (combinational); on ARVALID_M&ARREADY_M go RTRANS.
REQ-018 ARTRANS with ARVALID_M dropped (protocol violation): hold ARTRANS, no ARVALID asserted downstream.
REQ-019 RTRANS: ARREADY_M=0; each RVALID&RREADY beat decrements counter (saturating at 0); beat with RLAST=1 -> IDLE next cycle.
REQ-020 prot_err SHALL set on beat with RLAST=1 while counter!=0, or RLAST=0 while counter==0; cleared only by reset.
REQ-021 Rsel_Slave SHALL equal sel register in all states; unchanged until next IDLE acceptance.
REQ-022 Back-to-back bursts: ARVALID_M high in the IDLE cycle immediately following last beat is accepted; minimum gap between last beat and next slave ARVALID = 2 cycles.
REQ-023 RVALID without RREADY in RTRANS: no counter change, no transition.

Reset
REQ-024 ARESETn=0 at a rising edge SHALL force state=IDLE, Rsel_Slave=0, beat counter=0, prot_err=0; all ARVALID/ARREADY outputs 0 during and after reset until new acceptance.
REQ-025 Reset mid-burst (ARTRANS or RTRANS) SHALL abort unconditionally to IDLE; no outstanding-transfer recovery.

Structure
REQ-026 Read-state encodings, slave indices, DefaultSlave index, and address region table SHALL live in the shared AXI define package.
REQ-027 Address decoder SHALL be a separate combinational sub-module par_addr_decoder, parameterised by SlaveCount.
REQ-028 Expected size 120-250 lines RTL, single always_ff for state/sel/counter/prot_err.

Verification
REQ-029 ARADDR=0x0001_0004, ARLEN=0, ARREADY_SS[1] after 2 cycles, one RLAST beat -> Rsel_Slave=1, states IDLE->ARTRANS->RTRANS->IDLE, prot_err=0.
REQ-030 ARADDR=0xFFFF_0000 -> Rsel_Slave=4, ARVALID_DS=1, all ARVALID_SS=0.
REQ-031 ARLEN=3, four beats with RREADY toggling 1,0,1 -> counter reaches 0 on 4th beat, RLAST accepted, prot_err=0.
REQ-032 ARLEN=3, RLAST on 2nd beat -> prot_err=1, state IDLE, prot_err remains 1 over next burst.
REQ-033 ARESETn=0 during RTRANS of ARLEN=7 burst -> next cycle state=IDLE, Rsel_Slave=0, counter=0, prot_err=0.
REQ-034 Two consecutive bursts to slaves 0 then 2, second ARVALID_M held from last beat -> second accepted first IDLE cycle, Rsel_Slave switches 0->2.

Source files
------------

// File: rtl/par_read_ctrl_pkg.sv
// Shared AXI read-path definitions: read-state encodings, slave indices and
// the upper-address region table used by the read address decoder.
package par_read_ctrl_pkg;

    localparam int unsigned SLAVE_COUNT       = 5;
    localparam int unsigned SEL_SLAVE_W       = 3;
    localparam int unsigned LEN_W             = 4;
    localparam int unsigned REGION_COUNT      = 4;

    localparam int unsigned SLAVE0_IDX        = 0;
    localparam int unsigned SLAVE1_IDX        = 1;
    localparam int unsigned SLAVE2_IDX        = 2;
    localparam int unsigned SLAVE3_IDX        = 3;
    localparam int unsigned DEFAULT_SLAVE_IDX = SLAVE_COUNT - 1;

    typedef enum logic [1:0] {
        READSTATE_IDLE    = 2'd0,
        READSTATE_ARTRANS = 2'd1,
        READSTATE_RTRANS  = 2'd2
    } read_state_e;

    // Inclusive ARADDR[31:16] ranges, one per real slave
    localparam logic [15:0] REGION0_BASE = 16'h0000;
    localparam logic [15:0] REGION0_LAST = 16'h0000;
    localparam logic [15:0] REGION1_BASE = 16'h0001;
    localparam logic [15:0] REGION1_LAST = 16'h0001;
    localparam logic [15:0] REGION2_BASE = 16'h0002;
    localparam logic [15:0] REGION2_LAST = 16'h000F;
    localparam logic [15:0] REGION3_BASE = 16'h0010;
    localparam logic [15:0] REGION3_LAST = 16'h00FF;

    // Offset compare keeps the test free of always-true bounds
    function automatic logic in_range(input logic [15:0] hi,
                                      input logic [15:0] base,
                                      input logic [15:0] last);
        return 16'(hi - base) <= 16'(last - base);
    endfunction

    function automatic logic region_hit(input int idx, input logic [15:0] hi);
        case (idx)
            0:       return in_range(hi, REGION0_BASE, REGION0_LAST);
            1:       return in_range(hi, REGION1_BASE, REGION1_LAST);
            2:       return in_range(hi, REGION2_BASE, REGION2_LAST);
            3:       return in_range(hi, REGION3_BASE, REGION3_LAST);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/par_read_ctrl_addr_decoder.sv
// Combinational read-address decoder: maps ARADDR[31:16] onto a slave index,
// falling back to the DefaultSlave when no region matches.
module par_addr_decoder
    import par_read_ctrl_pkg::*;
#(
    parameter int unsigned SlaveCount = 5,
    parameter int unsigned SelW       = 3
) (
    input  logic [31:0]     addr,
    output logic [SelW-1:0] sel
);

    logic addr_lo_unused;
    assign addr_lo_unused = ^addr[15:0];

    // Walk downwards so the lowest matching region wins
    always_comb begin
        sel = SelW'(SlaveCount - 1);
        for (int i = int'(SlaveCount) - 2; i >= 0; i--) begin
            if (region_hit(i, addr[31:16])) begin
                sel = SelW'(i);
            end
        end
    end

endmodule

// File: rtl/par_read_ctrl.sv
// AXI read-channel controller: accepts one master read burst at a time,
// routes AR to the decoded slave and tracks R beats against ARLEN.
module par_read_ctrl
    import par_read_ctrl_pkg::*;
#(
    parameter int unsigned SlaveCount    = 5,
    parameter int unsigned SelSlaveCount = 3
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     ARVALID_M,
    output logic                     ARREADY_M,
    input  logic [31:0]              ARADDR_M,
    input  logic [LEN_W-1:0]         ARLEN_M,
    output logic [SlaveCount-2:0]    ARVALID_SS,
    input  logic [SlaveCount-2:0]    ARREADY_SS,
    output logic                     ARVALID_DS,
    input  logic                     ARREADY_DS,
    input  logic                     RVALID,
    input  logic                     RREADY,
    input  logic                     RLAST,
    output logic [1:0]               state,
    output logic [SelSlaveCount-1:0] Rsel_Slave,
    output logic                     prot_err
);

    read_state_e              state_q, state_d;
    logic [SelSlaveCount-1:0] sel_q, sel_d, dec_sel;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     cnt_zero;

    par_addr_decoder #(
        .SlaveCount (SlaveCount),
        .SelW       (SelSlaveCount)
    ) u_dec (
        .addr (ARADDR_M),
        .sel  (dec_sel)
    );

    assign cnt_zero   = (cnt_q == '0);
    assign state      = state_q;
    assign Rsel_Slave = sel_q;
    assign prot_err   = err_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= READSTATE_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // AR routing is combinational; held low while reset is asserted
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ARREADY_M  = 1'b0;
        ARVALID_SS = '0;
        ARVALID_DS = 1'b0;

        if (ARESETn) begin
            case (state_q)
                READSTATE_IDLE: begin
                    if (ARVALID_M) begin
                        sel_d   = dec_sel;
                        cnt_d   = ARLEN_M;
                        state_d = READSTATE_ARTRANS;
                    end
                end
                READSTATE_ARTRANS: begin
                    if (sel_q == SelSlaveCount'(SlaveCount - 1)) begin
                        ARVALID_DS = ARVALID_M;
                        ARREADY_M  = ARREADY_DS;
                    end
                    for (int i = 0; i < int'(SlaveCount) - 1; i++) begin
                        if (sel_q == SelSlaveCount'(i)) begin
                            ARVALID_SS[i] = ARVALID_M;
                            ARREADY_M     = ARREADY_SS[i];
                        end
                    end
                    if (ARVALID_M && ARREADY_M) begin
                        state_d = READSTATE_RTRANS;
                    end
                end
                READSTATE_RTRANS: begin
                    if (RVALID && RREADY) begin
                        cnt_d = cnt_zero ? cnt_q : LEN_W'(cnt_q - LEN_W'(1));
                        if (RLAST != cnt_zero) begin
                            err_d = 1'b1;
                        end
                        if (RLAST) begin
                            state_d = READSTATE_IDLE;
                        end
                    end
                end
                default: state_d = READSTATE_IDLE;
            endcase
        end
    end

endmodule
